// File: rtl/instruction_fetch.sv
// IF stage of the pipelined MIPS CPU: PC register, word-addressed instruction memory
// and the IF/ID pipeline register. Stall, flush and redirect arrive from later stages.
module instruction_fetch #(
  parameter int          INSTR_MEM_SIZE = 32,
  parameter logic [31:0] RESET_PC       = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_error,
  output logic [31:0] fetch_count
);

  localparam int ADDR_W = (INSTR_MEM_SIZE > 1) ? $clog2(INSTR_MEM_SIZE) : 1;

  // Contents are filled from outside (e.g. directly by a bench); the stage only reads.
  logic [31:0] data [INSTR_MEM_SIZE];

  logic [31:0] r_pc;
  logic [31:0] r_ifIdInstr;
  logic [31:0] r_ifIdPcPlus4;
  logic        r_ifIdValid;
  logic        r_fetchError;
  logic [31:0] r_fetchCount;

  logic [29:0]       w_wordIdx;
  logic [ADDR_W-1:0] w_memAddr;
  logic              w_inRange;
  logic [31:0]       w_fetchWord;
  logic [31:0]       w_pcPlus4;
  logic              w_load;
  logic              w_misaligned;

  assign w_wordIdx    = r_pc[31:2];
  assign w_memAddr    = w_wordIdx[ADDR_W-1:0];
  assign w_inRange    = ({2'b00, w_wordIdx} < 32'(INSTR_MEM_SIZE));
  // Out-of-range fetches read as a NOP so the pipeline keeps running after an error.
  assign w_fetchWord  = w_inRange ? data[w_memAddr] : 32'h00000000;
  assign w_pcPlus4    = r_pc + 32'd4;
  assign w_load       = !flush && !stall;
  assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Redirect beats stall so a resolved branch is never lost behind a load-use stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      r_pc <= w_pcPlus4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ifIdInstr   <= 32'h00000000;
      r_ifIdPcPlus4 <= 32'h00000000;
      r_ifIdValid   <= 1'b0;
      r_fetchCount  <= 32'h00000000;
    end else if (flush) begin
      r_ifIdInstr   <= 32'h00000000;
      r_ifIdPcPlus4 <= 32'h00000000;
      r_ifIdValid   <= 1'b0;
    end else if (!stall) begin
      r_ifIdInstr   <= w_fetchWord;
      r_ifIdPcPlus4 <= w_pcPlus4;
      r_ifIdValid   <= 1'b1;
      r_fetchCount  <= r_fetchCount + 32'd1;
    end
  end

  // Sticky until reset; an out-of-range word only counts as an error once it is latched.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetchError <= 1'b0;
    end else if (w_misaligned || (w_load && !w_inRange)) begin
      r_fetchError <= 1'b1;
    end
  end

  assign pc             = r_pc;
  assign if_id_instr    = r_ifIdInstr;
  assign if_id_pc_plus4 = r_ifIdPcPlus4;
  assign if_id_valid    = r_ifIdValid;
  assign fetch_error    = r_fetchError;
  assign fetch_count    = r_fetchCount;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall, flush/redirect,
// misaligned and out-of-range errors, PC wrap and mid-run reset.
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_error;
  logic [31:0] fetch_count;

  int totalChecks = 0;
  int badChecks   = 0;

  instruction_fetch #(
    .INSTR_MEM_SIZE(32),
    .RESET_PC      (32'h00000000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .fetch_error   (fetch_error),
    .fetch_count   (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Distinct, recognisable word per memory slot.
  function automatic logic [31:0] memWord(input int idx);
    return 32'h8C000000 + (32'(idx) << 8) + 32'(idx);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Set inputs, then advance one rising edge and settle before sampling.
  task automatic applyStimulus(input logic rst, input logic stl, input logic fl,
                               input logic rv, input logic [31:0] rpc);
    reset          = rst;
    stall          = stl;
    flush          = fl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clock);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [31:0] ePc,
                            input logic [31:0] eInstr, input logic [31:0] ePlus4,
                            input logic eValid, input logic eErr, input logic [31:0] eCount);
    checkOutput({tag, ".pc"},    pc,                    ePc);
    checkOutput({tag, ".instr"}, if_id_instr,           eInstr);
    checkOutput({tag, ".plus4"}, if_id_pc_plus4,        ePlus4);
    checkOutput({tag, ".valid"}, {31'd0, if_id_valid},  {31'd0, eValid});
    checkOutput({tag, ".err"},   {31'd0, fetch_error},  {31'd0, eErr});
    checkOutput({tag, ".count"}, fetch_count,           eCount);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dut.data[i] = memWord(i);
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkState("reset", 32'h0, 32'h0, 32'h0, 0, 0, 32'd0);

    // Sequential fetch
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("seq1", 32'h4, memWord(0), 32'h4, 1, 0, 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("seq2", 32'h8, memWord(1), 32'h8, 1, 0, 32'd2);

    // Stall two cycles at pc=8
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkState("stall1", 32'h8, memWord(1), 32'h8, 1, 0, 32'd2);
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkState("stall2", 32'h8, memWord(1), 32'h8, 1, 0, 32'd2);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("resume", 32'hC, memWord(2), 32'hC, 1, 0, 32'd3);

    // Taken branch: redirect + flush
    applyStimulus(0, 0, 1, 1, 32'h40);
    checkState("branch", 32'h40, 32'h0, 32'h0, 0, 0, 32'd3);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("target", 32'h44, memWord(16), 32'h44, 1, 0, 32'd4);

    // Redirect together with stall: redirect wins, IF/ID held
    applyStimulus(0, 1, 0, 1, 32'h10);
    checkState("redirStall", 32'h10, memWord(16), 32'h44, 1, 0, 32'd4);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("afterRS", 32'h14, memWord(4), 32'h14, 1, 0, 32'd5);

    // Misaligned redirect
    applyStimulus(0, 0, 1, 1, 32'h22);
    checkState("misalign", 32'h20, 32'h0, 32'h0, 0, 1, 32'd5);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("sticky", 32'h24, memWord(8), 32'h24, 1, 1, 32'd6);
    applyStimulus(0, 0, 1, 1, 32'h80);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("oorAfterErr", 32'h84, 32'h0, 32'h84, 1, 1, 32'd7);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkState("reset2", 32'h0, 32'h0, 32'h0, 0, 0, 32'd0);

    // Last in-range word, then first out-of-range word raises the error
    applyStimulus(0, 0, 1, 1, 32'h7C);
    checkState("toLast", 32'h7C, 32'h0, 32'h0, 0, 0, 32'd0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("lastWord", 32'h80, memWord(31), 32'h80, 1, 0, 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("oor", 32'h84, 32'h0, 32'h84, 1, 1, 32'd2);

    // PC wraps modulo 2^32
    applyStimulus(0, 0, 1, 1, 32'hFFFFFFFC);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("wrap", 32'h0, 32'h0, 32'h0, 1, 1, 32'd3);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("postWrap", 32'h4, memWord(0), 32'h4, 1, 1, 32'd4);

    // Reset mid-run with stall asserted
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkState("midReset", 32'h0, 32'h0, 32'h0, 0, 0, 32'd0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkState("firstAfter", 32'h4, memWord(0), 32'h4, 1, 0, 32'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
